prio_rr_arbiter: RTL and testbench
==================================

// Module: prio_rr_arbiter
// PURPOSE
//  Registered N-way arbiter; successor to the fixed 4-way priority arbiter.
//  Mode-selectable: fixed priority (programmable order) or round-robin over the same order.
//  Adds grant hold with a bounded hold timeout.
//  Sits in front of a shared resource; one-hot grant plus encoded winner id.
// PARAMETERS
//  N         4               number of requesters, 2..16
//  IDW       $clog2(N)       width of an id/slot index (derived, do not override)
//  PRIO_MAP  8'b10_00_01_11  N*IDW bits; slot s = PRIO_MAP[s*IDW +: IDW]; slot 0 highest (default order 3>1>0>2)
//  MAX_HOLD  8               max consecutive grant cycles to one holder while others wait; 0 = unlimited
// PORTS
//  clk       in   1    clock, rising edge
//  reset     in   1    asynchronous, active-low reset
//  req       in   N    request vector, level, bit i = requester i
//  mode      in   1    0 = fixed priority, 1 = round-robin
//  gnt       out  N    registered one-hot grant (all-zero = none)
//  gnt_id    out  IDW  index of granted requester; 0 when gnt_valid=0
//  gnt_valid out  1    OR of gnt
// BEHAVIOUR
//  - Reset (async assert, sync release): gnt=0, gnt_id=0, gnt_valid=0, rr_ptr=0, hold_cnt=0.
//  - Latency 1: req sampled at edge k -> gnt valid after edge k. Outputs never combinational from req.
//  - Decision each edge, in order:
//    a) HOLD: gnt_valid && req[gnt_id] && (MAX_HOLD==0 || hold_cnt<MAX_HOLD-1 || no other req)
//       -> keep gnt; hold_cnt++ (saturating at MAX_HOLD-1 when holder is sole requester).
//    b) TIMEOUT: holder still requesting, hold_cnt==MAX_HOLD-1, others requesting
//       -> arbitrate with holder masked out; hold_cnt=0.
//    c) ARBITRATE: holder dropped req or no grant -> pick among req; hold_cnt=0.
//    d) req==0 -> gnt=0, gnt_id=0, hold_cnt=0.
//  - Fixed mode: winner = requester in lowest slot with req set. rr_ptr held at 0.
//  - RR mode: scan slots from rr_ptr upward, wrap at N-1 -> 0; first requesting slot wins.
//    On each new grant (c or b), rr_ptr <= (winner_slot+1) mod N. Not updated in HOLD.
//  - Mode change: no effect on a held grant; applies at next arbitration. Switching to fixed clears rr_ptr.
//  - Holder drops req and others request in same cycle: new winner granted next edge, no idle gap.
//  - Holder deasserts and re-asserts: treated as a new request (hold_cnt restarts).
//  - Reset mid-hold: all state cleared immediately; the first post-reset decision is a fresh arbitration.
//  - PRIO_MAP must be a permutation of 0..N-1; duplicate entries are a configuration error (elaboration assertion).
// STRUCTURE
//  - Package arb_pkg: arb_mode_e {ARB_FIXED=1'b0, ARB_RR=1'b1}; default PRIO_MAP constant for N=4.
//  - Sub-module arb_pick (combinational): inputs req_slot[N] (req permuted into slot order), mask[N], start[IDW];
//    outputs found, slot[IDW]. Rotating first-one search. Top does the permutation, hold counter, rr_ptr, output registers.
// TESTING
//  1 Reset: drive req=4'hF during reset low -> gnt=0, gnt_valid=0; release -> next edge gnt=4'b1000, gnt_id=3.
//  2 Fixed order: mode=0, req=4'b0101 -> gnt=4'b0001; then req=4'b0100 -> gnt=4'b0100; req=4'b0110 from idle -> gnt=4'b0010.
//  3 Hold/timeout: mode=0, MAX_HOLD=8, req=4'b1001 held -> gnt=4'b1000 for exactly 8 cycles, then 4'b0001
//    for 8 cycles, then 4'b1000 again; req=4'b1000 alone -> gnt stays 4'b1000 indefinitely.
//  4 RR fairness: mode=1, req=4'hF, each granted requester drops req for one cycle after its grant
//    -> grant sequence 3,1,0,2,3,1... (slot order), no requester granted twice before all granted once.
//  5 Handover: holder 1 drops req while req[2] high -> gnt=4'b0100 next edge, gnt_valid never 0 between.
//  6 Reset mid-hold: assert reset while gnt=4'b0010 with hold_cnt=5 -> outputs 0 asynchronously;
//    after release with req=4'b0010 -> gnt=4'b0010 and a full MAX_HOLD window before any timeout.

Source files
------------

// File: rtl/prio_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the priority / round-robin arbiter.
//   arb_mode_e       : arbitration mode selector (fixed priority or round-robin)
//   ARB_PRIO_MAP_N4  : default slot-to-requester map for N=4 (order 3>1>0>2)
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // slot s = map[s*2 +: 2]; slot 0 is the highest priority
  localparam logic [7:0] ARB_PRIO_MAP_N4 = 8'b10_00_01_11;

endpackage

// File: rtl/prio_rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational rotating first-one search over requests already permuted
// into slot order.
//   req_slot [N]   : requests, bit s = request of the requester in slot s
//   mask     [N]   : bit s set excludes slot s from the search
//   start    [IDW] : first slot examined; search wraps N-1 -> 0
//   found          : at least one eligible slot exists
//   slot     [IDW] : first eligible slot at or after start (0 when !found)
// ---------------------------------------------------------------------------
module arb_pick
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_slot,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] slot
);

  logic [N-1:0] w_elig;
  int           w_idx;

  assign w_elig = req_slot & ~mask;

  always_comb begin
    found = 1'b0;
    slot  = '0;
    w_idx = 0;
    for (int k = 0; k < N; k++) begin
      // start is always < N, so a single conditional subtract wraps the index
      w_idx = int'(start) + k;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      if (!found && w_elig[w_idx]) begin
        found = 1'b1;
        slot  = IDW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/prio_rr_arbiter.sv
// ---------------------------------------------------------------------------
// prio_rr_arbiter
// Registered N-way arbiter with programmable priority order, fixed-priority
// or round-robin selection, and grant hold with a bounded hold timeout.
//   clk        in   1    clock, rising edge
//   reset      in   1    asynchronous assert, active-low reset
//   req        in   N    level requests, bit i = requester i
//   mode       in   1    0 = fixed priority, 1 = round-robin
//   gnt        out  N    registered one-hot grant (zero = none)
//   gnt_id     out  IDW  index of granted requester (0 when none)
//   gnt_valid  out  1    OR of gnt
// ---------------------------------------------------------------------------
module prio_rr_arbiter
  import arb_pkg::*;
#(
  parameter int               N        = 4,
  parameter int               IDW      = $clog2(N),  // derived; leave at default
  parameter logic [N*IDW-1:0] PRIO_MAP = ARB_PRIO_MAP_N4,
  parameter int               MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           mode,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  localparam int             HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 1) ? HCW'(MAX_HOLD - 1) : '0;

  // ---- configuration checks ------------------------------------------------
  if (N < 2 || N > 16) begin : g_bad_n
    $error("prio_rr_arbiter: N must be in 2..16");
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_map_chk
    for (genvar gj = gi + 1; gj < N; gj++) begin : g_pair
      if (PRIO_MAP[gi*IDW +: IDW] == PRIO_MAP[gj*IDW +: IDW]) begin : g_dup
        $error("prio_rr_arbiter: PRIO_MAP has a duplicate entry");
      end
    end
  end

  // ---- state ---------------------------------------------------------------
  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic           r_gnt_valid;
  logic [IDW-1:0] r_rr_ptr;
  logic [HCW-1:0] r_hold_cnt;

  // ---- combinational ------------------------------------------------------
  arb_mode_e      w_mode;
  logic [N-1:0]   w_req_slot;
  logic [N-1:0]   w_holder_slot;
  logic [N-1:0]   w_mask_slot;
  logic           w_holder_req;
  logic           w_others;
  logic           w_hold;
  logic           w_timeout;
  logic [IDW-1:0] w_start;
  logic           w_found;
  logic [IDW-1:0] w_win_slot;
  logic [IDW-1:0] w_win_id;

  logic [N-1:0]   w_gnt_next;
  logic [IDW-1:0] w_gnt_id_next;
  logic           w_gnt_valid_next;
  logic [IDW-1:0] w_rr_ptr_next;
  logic [HCW-1:0] w_hold_cnt_next;

  assign w_mode = arb_mode_e'(mode);

  // Permute requests into slot order and mark the slot owned by the holder.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    assign w_req_slot[gi]    = req[PRIO_MAP[gi*IDW +: IDW]];
    assign w_holder_slot[gi] = (PRIO_MAP[gi*IDW +: IDW] == r_gnt_id);
  end

  assign w_holder_req = r_gnt_valid && req[r_gnt_id];
  assign w_others     = |(req & ~r_gnt);

  always_comb begin
    w_hold = 1'b0;
    if (MAX_HOLD == 0) begin
      w_hold = w_holder_req;
    end else begin
      // a sole requester keeps the grant even once the window is used up
      w_hold = w_holder_req && ((r_hold_cnt < HOLD_LAST) || !w_others);
    end
  end

  // Holder still requesting but not allowed to hold: its window expired.
  assign w_timeout   = w_holder_req && !w_hold;
  assign w_mask_slot = w_timeout ? w_holder_slot : '0;
  assign w_start     = (w_mode == ARB_RR) ? r_rr_ptr : '0;

  arb_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req_slot (w_req_slot),
    .mask     (w_mask_slot),
    .start    (w_start),
    .found    (w_found),
    .slot     (w_win_slot)
  );

  assign w_win_id = PRIO_MAP[int'(w_win_slot)*IDW +: IDW];

  always_comb begin
    w_gnt_next       = '0;
    w_gnt_id_next    = '0;
    w_gnt_valid_next = 1'b0;
    w_hold_cnt_next  = '0;
    w_rr_ptr_next    = r_rr_ptr;

    if (w_hold) begin
      w_gnt_next       = r_gnt;
      w_gnt_id_next    = r_gnt_id;
      w_gnt_valid_next = 1'b1;
      w_hold_cnt_next  = (r_hold_cnt < HOLD_LAST) ? r_hold_cnt + 1'b1 : r_hold_cnt;
    end else if (w_found) begin
      // fresh grant (new arbitration or timeout handover)
      w_gnt_next       = {{(N-1){1'b0}}, 1'b1} << w_win_id;
      w_gnt_id_next    = w_win_id;
      w_gnt_valid_next = 1'b1;
      w_rr_ptr_next    = (w_win_slot == IDW'(N - 1)) ? '0 : w_win_slot + 1'b1;
    end

    // round-robin pointer only lives in round-robin mode
    if (w_mode == ARB_FIXED) begin
      w_rr_ptr_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_rr_ptr    <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_gnt       <= w_gnt_next;
      r_gnt_id    <= w_gnt_id_next;
      r_gnt_valid <= w_gnt_valid_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_hold_cnt  <= w_hold_cnt_next;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prio_rr_arbiter
// Directed bench for prio_rr_arbiter (N=4, default map 3>1>0>2, MAX_HOLD=8).
// The driver pushes the hand-computed grant expected after each edge into a
// queue; a monitor pops one entry per edge and compares the registered
// outputs.
// ---------------------------------------------------------------------------
module tb_prio_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       mode;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_q[$];   // {gnt[3:0], gnt_id[1:0], gnt_valid}
  string      name_q[$];

  always #5 clk = ~clk;

  prio_rr_arbiter #(
    .N        (4),
    .PRIO_MAP (8'b10_00_01_11),
    .MAX_HOLD (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .mode      (mode),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  function automatic logic [1:0] id_of(input logic [3:0] g);
    case (g)
      4'b0010: id_of = 2'd1;
      4'b0100: id_of = 2'd2;
      4'b1000: id_of = 2'd3;
      default: id_of = 2'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_next(input logic [3:0] eg, input string nm);
    exp_q.push_back({eg, id_of(eg), |eg});
    name_q.push_back(nm);
  endtask

  task automatic step(input logic [3:0] r, input logic m, input logic [3:0] eg, input string nm);
    @(negedge clk);
    req  = r;
    mode = m;
    expect_next(eg, nm);
  endtask

  // monitor: one transaction per clock edge that has an expectation queued
  initial begin
    logic [6:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        $display("txn %-14s req=%b mode=%0d gnt=%b id=%0d valid=%0d", nm, req, mode, gnt, gnt_id, gnt_valid);
        chk({nm, "_gnt"},   32'(gnt),       32'(e[6:3]));
        chk({nm, "_id"},    32'(gnt_id),    32'(e[2:1]));
        chk({nm, "_valid"}, 32'(gnt_valid), 32'(e[0]));
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  int rr_seq [8] = '{3, 1, 0, 2, 3, 1, 0, 2};

  initial begin
    logic [3:0] r;

    // 1: reset with all requesting, then first grant goes to slot 0 (req 3)
    reset = 1'b0;
    req   = 4'hF;
    mode  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_rst_gnt",   32'(gnt),       32'h0);
    chk("t1_rst_id",    32'(gnt_id),    32'h0);
    chk("t1_rst_valid", 32'(gnt_valid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    expect_next(4'b1000, "t1_release");
    step(4'b0000, 1'b0, 4'b0000, "t1_idle");

    // 2: fixed priority order 3>1>0>2
    step(4'b0101, 1'b0, 4'b0001, "t2_0101");
    step(4'b0100, 1'b0, 4'b0100, "t2_0100");
    step(4'b0000, 1'b0, 4'b0000, "t2_idle");
    step(4'b0110, 1'b0, 4'b0010, "t2_0110");
    step(4'b0110, 1'b0, 4'b0010, "t2_0110_hold");
    step(4'b0000, 1'b0, 4'b0000, "t2_idle2");

    // 3: hold window of 8 cycles alternating between 3 and 0
    for (int i = 0; i < 8; i++) step(4'b1001, 1'b0, 4'b1000, "t3_hold3");
    for (int i = 0; i < 8; i++) step(4'b1001, 1'b0, 4'b0001, "t3_hold0");
    for (int i = 0; i < 2; i++) step(4'b1001, 1'b0, 4'b1000, "t3_back3");
    for (int i = 0; i < 20; i++) step(4'b1000, 1'b0, 4'b1000, "t3_sole");
    // saturated counter: a competitor forces immediate timeout
    step(4'b1001, 1'b0, 4'b0001, "t3_sat_to");
    step(4'b0000, 1'b0, 4'b0000, "t3_idle");

    // 4: round-robin fairness, each winner drops its request for one cycle
    r = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step(r, 1'b1, 4'b0001 << rr_seq[i], "t4_rr");
      r = 4'hF & ~(4'b0001 << rr_seq[i]);
    end
    step(4'b0000, 1'b1, 4'b0000, "t4_idle");

    // mode change: fixed clears rr_ptr; held grant unaffected by mode
    step(4'b0101, 1'b1, 4'b0001, "tm_rr_a");      // rr_ptr -> 3
    step(4'b0000, 1'b0, 4'b0000, "tm_fix_idle");  // rr_ptr cleared
    step(4'b0101, 1'b1, 4'b0001, "tm_rr_b");      // from slot 0 again
    step(4'b0000, 1'b1, 4'b0000, "tm_rr_idle");   // rr_ptr stays 3
    step(4'b0101, 1'b1, 4'b0100, "tm_rr_c");      // from slot 3 -> req 2
    step(4'b0101, 1'b0, 4'b0100, "tm_held");      // hold survives mode change
    step(4'b0000, 1'b0, 4'b0000, "tm_idle");

    // 5: handover without idle gap
    step(4'b0010, 1'b0, 4'b0010, "t5_own1");
    step(4'b0110, 1'b0, 4'b0010, "t5_hold1");
    step(4'b0100, 1'b0, 4'b0100, "t5_hand2");
    step(4'b0000, 1'b0, 4'b0000, "t5_idle");

    // 6: reset while holder 1 has hold_cnt=5
    step(4'b0010, 1'b0, 4'b0010, "t6_own1");
    for (int i = 0; i < 5; i++) step(4'b0110, 1'b0, 4'b0010, "t6_hold");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_async_gnt",   32'(gnt),       32'h0);
    chk("t6_async_id",    32'(gnt_id),    32'h0);
    chk("t6_async_valid", 32'(gnt_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0110;
    mode  = 1'b0;
    expect_next(4'b0010, "t6_fresh");
    for (int i = 0; i < 7; i++) step(4'b0110, 1'b0, 4'b0010, "t6_window");
    step(4'b0110, 1'b0, 4'b0100, "t6_timeout");
    step(4'b0000, 1'b0, 4'b0000, "t6_idle");

    // drain the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
